spi_reg_bank: RTL and testbench

Register bank directly downstream of the SPI slave interface. It consumes the slave's decoded address, write payload and valid strobes, commits writes to control registers, and returns read data to the slave's `tx_d` input for shift-out on MISO. It also collects status and sticky events for the host and raises an interrupt from them.

---
 rtl/spi_reg_bank_pkg.sv | 19 +
 rtl/spi_edge_det.sv | 30 +++
 rtl/spi_reg_bank.sv | 194 +++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_bank_pkg.sv
// rtl/spi_reg_bank_pkg.sv - shared address map constants and FSM state type for spi_reg_bank
package spi_reg_bank_pkg;

  // Fixed-function register addresses; CTRL occupies 0x00 up to CTRL_SPAN-1 at most
  localparam int unsigned CTRL_SPAN   = 32'h40;
  localparam int unsigned ADDR_STATUS = 32'h40;
  localparam int unsigned ADDR_EVENT  = 32'h41;
  localparam int unsigned ADDR_MASK   = 32'h42;
  localparam int unsigned ADDR_ERRCNT = 32'h43;
  localparam int unsigned ADDR_ID     = 32'h7F;

  // Transaction tracking: waiting for header, header seen, write already committed
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DONE = 2'd2
  } rb_state_t;

endpackage

// File: rtl/spi_edge_det.sv
// rtl/spi_edge_det.sv - 1-bit level to registered rise/fall pulse detector
module spi_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_d;
  logic r_rise;
  logic r_fall;

  // Delay the level one cycle and register the rise/fall pulses derived from it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d    <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_d    <= i_d;
      r_rise <= i_d & ~r_d;
      r_fall <= ~i_d & r_d;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI slave register bank (CTRL/STATUS/EVENT/MASK/ID); SPI_REG_BANK_ERRCNT_EN adds the 0x43 error counter
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int                  ADDRSZ   = 7,
  parameter int                  PAYLOAD  = 8,
  parameter int                  NREGS    = 8,
  parameter logic [PAYLOAD-1:0]  ID_VALUE = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDRSZ-1:0]          addr,
  input  logic                       addr_dv,
  input  logic [PAYLOAD-1:0]         rx_d,
  input  logic                       rxdv,
  input  logic                       rxer,
  output logic [PAYLOAD-1:0]         tx_d,
  input  logic [PAYLOAD-1:0]         status_i,
  input  logic [PAYLOAD-1:0]         event_i,
  output logic [NREGS*PAYLOAD-1:0]   ctrl_o,
  output logic                       wr_pulse_o,
  output logic [ADDRSZ-1:0]          wr_addr_o,
  output logic                       irq_o
);

  rb_state_t          r_state;
  logic [ADDRSZ-1:0]  r_addr_q;
  logic               r_wr_pulse;
  logic [ADDRSZ-1:0]  r_wr_addr;
  logic               r_irq;
  logic [PAYLOAD-1:0] r_ctrl [NREGS];
  logic [PAYLOAD-1:0] r_event;
  logic [PAYLOAD-1:0] r_mask;

  logic               w_addr_rise;
  logic               w_addr_fall;
  logic               w_rxdv_rise;
  logic               w_rxdv_fall;
  logic               w_rxer_rise;
  logic               w_rxer_fall;

  logic [31:0]        w_addr_u;
  logic [31:0]        w_q_u;
  logic [PAYLOAD-1:0] w_rd_val;
  logic               w_commit;
  logic               w_hit_ctrl;
  logic               w_hit_event;
  logic               w_hit_mask;
  logic               w_hit_errcnt;
  logic               w_illegal;
  logic [PAYLOAD-1:0] w_clr;

`ifdef SPI_REG_BANK_ERRCNT_EN
  logic [7:0]         r_errcnt;
  logic               w_err_inc;
`endif

  spi_edge_det u_addr_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (addr_dv),
    .o_rise  (w_addr_rise),
    .o_fall  (w_addr_fall)
  );

  spi_edge_det u_rxdv_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rxdv),
    .o_rise  (w_rxdv_rise),
    .o_fall  (w_rxdv_fall)
  );

  spi_edge_det u_rxer_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rxer),
    .o_rise  (w_rxer_rise),
    .o_fall  (w_rxer_fall)
  );

  // Read mux on the live header address; only consumed on an addr_dv rise
  always_comb begin
    w_addr_u = 32'(addr);
    w_rd_val = '0;
    for (int n = 0; n < NREGS; n++) begin
      if (w_addr_u == 32'(n)) w_rd_val = r_ctrl[n];
    end
    case (w_addr_u)
      ADDR_STATUS: w_rd_val = status_i;
      ADDR_EVENT:  w_rd_val = r_event;
      ADDR_MASK:   w_rd_val = r_mask;
`ifdef SPI_REG_BANK_ERRCNT_EN
      ADDR_ERRCNT: w_rd_val = PAYLOAD'(r_errcnt);
`endif
      ADDR_ID:     w_rd_val = ID_VALUE;
      default:     ;
    endcase
  end

  // Write decode against the latched header address
  always_comb begin
    w_q_u       = 32'(r_addr_q);
    w_commit    = (r_state == HDR) && w_rxdv_rise;
    w_hit_ctrl  = (w_q_u < 32'(NREGS)) && (w_q_u < CTRL_SPAN);
    w_hit_event = (w_q_u == ADDR_EVENT);
    w_hit_mask  = (w_q_u == ADDR_MASK);
`ifdef SPI_REG_BANK_ERRCNT_EN
    w_hit_errcnt = (w_q_u == ADDR_ERRCNT);
`else
    w_hit_errcnt = 1'b0;
`endif
    w_illegal   = !(w_hit_ctrl || w_hit_event || w_hit_mask || w_hit_errcnt);
    w_clr       = (w_commit && w_hit_event) ? rx_d : '0;
  end

  // Transaction FSM: latch header and read data, commit at most one write per header
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_addr_q   <= '0;
      tx_d       <= '0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_addr_rise) begin
            r_addr_q <= addr;
            tx_d     <= w_rd_val;
            r_state  <= HDR;
          end
        end
        HDR: begin
          if (w_rxdv_rise) begin
            r_wr_pulse <= 1'b1;
            r_wr_addr  <= r_addr_q;
            r_state    <= w_addr_fall ? IDLE : DONE;
          end else if (w_addr_fall) begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          if (w_addr_fall) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // CTRL/MASK loads and sticky EVENT bits; a same-cycle event set beats a W1C clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NREGS; n++) r_ctrl[n] <= '0;
      r_mask  <= '0;
      r_event <= '0;
    end else begin
      r_event <= (r_event & ~w_clr) | event_i;
      if (w_commit) begin
        for (int n = 0; n < NREGS; n++) begin
          if (w_hit_ctrl && (w_q_u == 32'(n))) r_ctrl[n] <= rx_d;
        end
        if (w_hit_mask) r_mask <= rx_d;
      end
    end
  end

  // Interrupt follows the masked sticky events one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= |(r_event & r_mask);
  end

`ifdef SPI_REG_BANK_ERRCNT_EN
  assign w_err_inc = w_rxer_rise | (w_commit & w_illegal) | ((r_state == IDLE) & w_rxdv_rise);

  // Saturating error counter; a write to it clears, coincident error sources count once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           r_errcnt <= 8'h00;
    else if (w_commit && w_hit_errcnt)      r_errcnt <= 8'h00;
    else if (w_err_inc && r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'h01;
  end
`endif

  for (genvar g = 0; g < NREGS; g++) begin : g_ctrl
    assign ctrl_o[g*PAYLOAD +: PAYLOAD] = r_ctrl[g];
  end

  assign wr_pulse_o = r_wr_pulse;
  assign wr_addr_o  = r_wr_addr;
  assign irq_o      = r_irq;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - directed self-checking bench for spi_reg_bank (both SPI_REG_BANK_ERRCNT_EN builds)
module tb_spi_reg_bank;
  import spi_reg_bank_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  addr = '0;
  logic        addr_dv = 1'b0;
  logic [7:0]  rx_d = '0;
  logic        rxdv = 1'b0;
  logic        rxer = 1'b0;
  logic [7:0]  tx_d;
  logic [7:0]  status_i = 8'h5A;
  logic [7:0]  event_i = '0;
  logic [63:0] ctrl_o;
  logic        wr_pulse_o;
  logic [6:0]  wr_addr_o;
  logic        irq_o;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  spi_reg_bank dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addr       (addr),
    .addr_dv    (addr_dv),
    .rx_d       (rx_d),
    .rxdv       (rxdv),
    .rxer       (rxer),
    .tx_d       (tx_d),
    .status_i   (status_i),
    .event_i    (event_i),
    .ctrl_o     (ctrl_o),
    .wr_pulse_o (wr_pulse_o),
    .wr_addr_o  (wr_addr_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (wr_pulse_o) pulse_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hdr(input logic [6:0] a);
    addr = a; addr_dv = 1'b1; tick(3);
  endtask

  task automatic pay(input logic [7:0] d);
    rx_d = d; rxdv = 1'b1; tick(2);
  endtask

  task automatic fin();
    rxdv = 1'b0; addr_dv = 1'b0; tick(3);
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] v);
    addr = a; addr_dv = 1'b1; tick(2);
    v = tx_d;
    tick(1); addr_dv = 1'b0; tick(3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick(3);
    checks++; if (tx_d !== 8'h00) begin failures++; $display("FAIL reset_tx_d got=%h exp=00", tx_d); end
    checks++; if (ctrl_o !== 64'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", ctrl_o); end
    checks++; if (wr_pulse_o !== 1'b0 || wr_addr_o !== 7'h00) begin failures++; $display("FAIL reset_wr got=%b/%h exp=0/00", wr_pulse_o, wr_addr_o); end
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    reset_n = 1'b1; tick(2);
  endtask

  task automatic test_ctrl_write();
    hdr(7'h02);
    rx_d = 8'h3C; rxdv = 1'b1; tick(1);
    checks++; if (wr_pulse_o !== 1'b0) begin failures++; $display("FAIL wr_early got=%b exp=0", wr_pulse_o); end
    tick(1);
    checks++; if (wr_pulse_o !== 1'b1 || wr_addr_o !== 7'h02) begin failures++; $display("FAIL wr_pulse got=%b/%h exp=1/02", wr_pulse_o, wr_addr_o); end
    checks++; if (ctrl_o !== 64'h0000_0000_003C_0000) begin failures++; $display("FAIL wr_ctrl got=%h exp=3c0000", ctrl_o); end
    fin();
    checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL wr_pulse_cnt got=%0d exp=1", pulse_cnt); end
  endtask

  task automatic test_read_id();
    logic [7:0] v;
    addr = 7'h7F; addr_dv = 1'b1; tick(1);
    checks++; if (tx_d !== 8'h00) begin failures++; $display("FAIL id_early got=%h exp=00", tx_d); end
    tick(1);
    checks++; if (tx_d !== 8'hA5) begin failures++; $display("FAIL id_read got=%h exp=a5", tx_d); end
    addr = 7'h02; tick(1); addr_dv = 1'b0; tick(5);
    checks++; if (tx_d !== 8'hA5) begin failures++; $display("FAIL id_hold got=%h exp=a5", tx_d); end
    rd(7'h02, v);
    checks++; if (v !== 8'h3C) begin failures++; $display("FAIL ctrl_read got=%h exp=3c", v); end
  endtask

  task automatic test_event_irq();
    logic [7:0] v;
    event_i = 8'h05; tick(1); event_i = 8'h00; tick(2);
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_unmasked got=%b exp=0", irq_o); end
    hdr(7'h42); pay(8'h04);
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_lag got=%b exp=0", irq_o); end
    tick(1);
    checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq_o); end
    fin();
    rd(7'h41, v);
    checks++; if (v !== 8'h05) begin failures++; $display("FAIL event_read got=%h exp=05", v); end
    hdr(7'h41); pay(8'h04); tick(1);
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_clr got=%b exp=0", irq_o); end
    fin();
    rd(7'h41, v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL w1c_read got=%h exp=01", v); end
    hdr(7'h41);
    checks++; if (tx_d !== 8'h01) begin failures++; $display("FAIL event_preclr got=%h exp=01", tx_d); end
    rx_d = 8'h04; rxdv = 1'b1; tick(1);
    event_i = 8'h04; tick(1); event_i = 8'h00; tick(1);
    checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL set_wins_irq got=%b exp=1", irq_o); end
    fin();
    rd(7'h41, v);
    checks++; if (v !== 8'h05) begin failures++; $display("FAIL set_wins got=%h exp=05", v); end
  endtask

  task automatic test_back_to_back();
    int p0;
    hdr(7'h00); pay(8'h11); fin();
    hdr(7'h07); pay(8'hEE); fin();
    p0 = pulse_cnt;
    hdr(7'h03); pay(8'h33);
    rxdv = 1'b0; tick(2);
    rx_d = 8'h44; rxdv = 1'b1; tick(3);
    fin();
    checks++; if (pulse_cnt !== p0 + 1) begin failures++; $display("FAIL done_ignore_cnt got=%0d exp=%0d", pulse_cnt, p0 + 1); end
    checks++; if (ctrl_o !== 64'hEE00_0000_333C_0011) begin failures++; $display("FAIL b2b_ctrl got=%h exp=ee000000333c0011", ctrl_o); end
  endtask

  task automatic test_errors();
    logic [7:0] v;
    int p0;
    p0 = pulse_cnt;
    hdr(7'h40); pay(8'hFF);
    checks++; if (wr_pulse_o !== 1'b1 || wr_addr_o !== 7'h40) begin failures++; $display("FAIL ro_pulse got=%b/%h exp=1/40", wr_pulse_o, wr_addr_o); end
    fin();
    rd(7'h40, v);
    checks++; if (v !== 8'h5A) begin failures++; $display("FAIL status_read got=%h exp=5a", v); end
    rx_d = 8'h12; rxdv = 1'b1; tick(3); rxdv = 1'b0; tick(2);
    checks++; if (pulse_cnt !== p0 + 1) begin failures++; $display("FAIL idle_rxdv_cnt got=%0d exp=%0d", pulse_cnt, p0 + 1); end
    rxer = 1'b1; tick(1); rxer = 1'b0; tick(3);
`ifdef SPI_REG_BANK_ERRCNT_EN
    rd(7'h43, v);
    checks++; if (v !== 8'h03) begin failures++; $display("FAIL errcnt3 got=%h exp=03", v); end
    hdr(7'h43); pay(8'h55); fin();
    rd(7'h43, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL errcnt_clr got=%h exp=00", v); end
    for (int i = 0; i < 300; i++) begin
      rxer = 1'b1; tick(1); rxer = 1'b0; tick(1);
    end
    tick(3);
    rd(7'h43, v);
    checks++; if (v !== 8'hFF) begin failures++; $display("FAIL errcnt_sat got=%h exp=ff", v); end
`else
    rd(7'h43, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL errcnt_off got=%h exp=00", v); end
    hdr(7'h43); pay(8'h55);
    checks++; if (wr_pulse_o !== 1'b1 || wr_addr_o !== 7'h43) begin failures++; $display("FAIL errcnt_off_pulse got=%b/%h exp=1/43", wr_pulse_o, wr_addr_o); end
    fin();
    rd(7'h43, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL errcnt_off_wr got=%h exp=00", v); end
`endif
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pulse_cnt;
    hdr(7'h01);
    rx_d = 8'h77;
    reset_n = 1'b0; #1;
    checks++; if (ctrl_o !== 64'h0 || tx_d !== 8'h00 || irq_o !== 1'b0) begin failures++; $display("FAIL mid_reset_async got=%h/%h/%b exp=0/00/0", ctrl_o, tx_d, irq_o); end
    checks++; if (dut.r_state !== IDLE) begin failures++; $display("FAIL mid_reset_state got=%0d exp=%0d", dut.r_state, IDLE); end
    addr_dv = 1'b0; tick(2);
    reset_n = 1'b1; tick(4);
    checks++; if (ctrl_o[15:8] !== 8'h00 || pulse_cnt !== p0) begin failures++; $display("FAIL mid_reset_nowrite got=%h/%0d exp=00/%0d", ctrl_o[15:8], pulse_cnt, p0); end
    checks++; if (dut.r_state !== IDLE) begin failures++; $display("FAIL mid_reset_idle got=%0d exp=%0d", dut.r_state, IDLE); end
  endtask

  initial begin
    test_reset();
    test_ctrl_write();
    test_read_id();
    test_event_irq();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
